// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a FIFO_DEPTH-byte queue drains into a
// start/data/stop serializer that chains frames with no idle gap.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       data_out_TX,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_line;
    logic             r_done;

    logic w_push;
    logic w_pop;
    logic w_fifo_empty;
    logic w_bit_end;
    logic w_line_next;
    logic w_done_next;

    assign tx_ready     = (r_count != OCC_FULL);
    assign w_push       = tx_valid & tx_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_bit_end    = (r_baud_cnt == BIT_LAST);

    assign data_out_TX = r_line;
    assign tx_busy     = (r_state != S_IDLE);
    assign tx_done     = r_done;

    always_comb begin
        w_state_next = r_state;
        w_line_next  = r_line;
        w_done_next  = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_line_next  = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                    w_line_next  = r_shift[0];
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_line_next  = 1'b1;
                    end else begin
                        w_line_next = r_shift[1];
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_done_next = 1'b1;
                    // Chain straight into the next start bit when bytes are waiting.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_line_next  = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_line_next  = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_line     <= 1'b1;
            r_done     <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
        end else begin
            r_state <= w_state_next;
            r_line  <= w_line_next;
            r_done  <= w_done_next;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_shift  <= r_mem[r_rd_ptr];
            end else if (r_state == S_DATA && w_bit_end) begin
                r_shift <= {1'b0, r_shift[7:1]};
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (r_state == S_IDLE) begin
                r_baud_cnt <= '0;
            end else if (w_bit_end) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end

            if (r_state == S_DATA && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: exact frame timing, back-to-back chaining,
// full-buffer drop, reset mid-frame and pointer wrap, plus a line receiver.
module tb_uart_tx_fifo;

    localparam int CPB = 87;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       data_out_TX;
    logic       tx_busy;
    logic       tx_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int         done_cnt = 0;
    int         done_q[$];
    logic [7:0] rx_q[$];
    int         rx_ferr = 0;
    logic       rx_en   = 1'b0;
    logic       rx_busy = 1'b0;
    int         rx_t    = 0;
    logic [7:0] rx_sh   = 8'h00;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .data_out_TX(data_out_TX),
        .tx_busy    (tx_busy),
        .tx_done    (tx_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_q.push_back(cyc);
        end
    end

    // Mid-bit sampling receiver, synchronised on the falling start edge.
    always @(negedge clk) begin
        if (!rx_busy) begin
            if (rx_en && data_out_TX === 1'b0) begin
                rx_busy <= 1'b1;
                rx_t    <= 1;
            end
        end else begin
            rx_t <= rx_t + 1;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB >= 1 && rx_t / CPB <= 8) begin
                    rx_sh[rx_t / CPB - 1] <= data_out_TX;
                end else if (rx_t / CPB == 9) begin
                    rx_busy <= 1'b0;
                    rx_q.push_back(rx_sh);
                    if (data_out_TX !== 1'b1) rx_ferr <= rx_ferr + 1;
                end
            end
        end
    end

    initial begin
        #(10 * 100000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered at the first sample after the pop edge; leaves at the last stop-bit sample.
    task automatic frame(input logic [7:0] b, input string tag);
        logic [9:0] obs;
        int unstable;
        int busy_lo;
        int done_hi;
        obs = '0;
        unstable = 0;
        busy_lo = 0;
        done_hi = 0;
        for (int bi = 0; bi < 10; bi++) begin
            for (int c = 0; c < CPB; c++) begin
                if (bi != 0 || c != 0) @(negedge clk);
                if (c == 0) obs[bi] = data_out_TX;
                else if (data_out_TX !== obs[bi]) unstable++;
                if (tx_busy !== 1'b1) busy_lo++;
                if ((bi != 0 || c != 0) && tx_done !== 1'b0) done_hi++;
            end
        end
        check({tag, "_bits"}, {22'd0, obs}, {22'd0, 1'b1, b, 1'b0});
        check({tag, "_stable"}, unstable, 0);
        check({tag, "_busy"}, busy_lo, 0);
        check({tag, "_nodone"}, done_hi, 0);
    endtask

    task automatic wait_not_busy(input int budget, input string tag);
        int n;
        n = 0;
        while (tx_busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, {31'd0, tx_busy}, 0);
    endtask

    initial begin
        int nl, nb, nd, d0, tmo, n;
        logic [10:0] rdy;
        logic [7:0]  exp_w [20];

        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_line", {31'd0, data_out_TX}, 1);
        check("rst_busy", {31'd0, tx_busy}, 0);
        check("rst_done", {31'd0, tx_done}, 0);
        check("rst_ready", {31'd0, tx_ready}, 1);
        rx_en = 1'b1;

        // Idle
        d0 = done_cnt;
        nl = 0; nb = 0; nd = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (data_out_TX !== 1'b1) nl++;
            if (tx_busy !== 1'b0) nb++;
            if (tx_done !== 1'b0) nd++;
        end
        check("idle_line", nl, 0);
        check("idle_busy", nb, 0);
        check("idle_done", nd, 0);
        check("idle_done_cnt", done_cnt, d0);

        // Single byte
        tx_data = 8'h4F;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        check("single_pre_line", {31'd0, data_out_TX}, 1);
        @(negedge clk);
        frame(8'h4F, "single");
        @(negedge clk);
        check("single_done", {31'd0, tx_done}, 1);
        check("single_busy_fall", {31'd0, tx_busy}, 0);
        check("single_line_idle", {31'd0, data_out_TX}, 1);
        @(negedge clk);
        check("single_done_pulse", {31'd0, tx_done}, 0);
        check("single_rx_cnt", rx_q.size(), 1);
        check("single_rx_byte", {24'd0, rx_q[0]}, 32'h4F);
        rx_q.delete();

        // Back-to-back "OK\r"
        d0 = done_q.size();
        fork
            begin
                tx_data = 8'h4F;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_data = 8'h4B;
                @(negedge clk);
                tx_data = 8'h0D;
                @(negedge clk);
                tx_valid = 1'b0;
            end
            begin
                @(negedge clk);
                @(negedge clk);
                frame(8'h4F, "b2b0");
                @(negedge clk);
                check("b2b_done0", {31'd0, tx_done}, 1);
                frame(8'h4B, "b2b1");
                @(negedge clk);
                check("b2b_done1", {31'd0, tx_done}, 1);
                frame(8'h0D, "b2b2");
                @(negedge clk);
                check("b2b_done2", {31'd0, tx_done}, 1);
                check("b2b_busy_fall", {31'd0, tx_busy}, 0);
            end
        join
        repeat (2) @(negedge clk);
        check("b2b_done_cnt", done_q.size() - d0, 3);
        check("b2b_gap01", done_q[d0 + 1] - done_q[d0], 870);
        check("b2b_gap12", done_q[d0 + 2] - done_q[d0 + 1], 870);
        check("b2b_rx_cnt", rx_q.size(), 3);
        check("b2b_rx_text", {8'd0, rx_q[0], rx_q[1], rx_q[2]}, 32'h004F4B0D);
        rx_q.delete();

        // Full buffer
        for (int k = 0; k < 10; k++) begin
            tx_data = 8'(k);
            tx_valid = 1'b1;
            rdy[k] = tx_ready;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        rdy[10] = tx_ready;
        check("full_ready_seq", {21'd0, rdy}, 32'h1FF);
        wait_not_busy(9 * 870 + 200, "full");
        repeat (2) @(negedge clk);
        check("full_rx_cnt", rx_q.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("full_rx%0d", i), {24'd0, rx_q[i]}, i);
        end
        rx_q.delete();

        // Reset mid-frame, with a write attempted during reset
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_data = 8'h11;
        @(negedge clk);
        tx_data = 8'h22;
        @(negedge clk);
        tx_data = 8'h33;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (4 * CPB + 38) @(negedge clk);
        check("rst_mid_bit3", {31'd0, data_out_TX}, 0);
        d0 = done_cnt;
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        tx_valid = 1'b0;
        check("rst_mid_line", {31'd0, data_out_TX}, 1);
        check("rst_mid_busy", {31'd0, tx_busy}, 0);
        check("rst_mid_ready", {31'd0, tx_ready}, 1);
        nl = 0; nb = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (data_out_TX !== 1'b1) nl++;
            if (tx_busy !== 1'b0) nb++;
        end
        check("rst_mid_quiet_line", nl, 0);
        check("rst_mid_quiet_busy", nb, 0);
        check("rst_mid_no_done", done_cnt, d0);
        rx_q.delete();
        tx_data = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'd0, tx_busy}, 1);
        wait_not_busy(1000, "post_rst");
        repeat (2) @(negedge clk);
        check("post_rst_rx_cnt", rx_q.size(), 1);
        check("post_rst_rx_byte", {24'd0, rx_q[0]}, 32'h3C);
        check("post_rst_done_cnt", done_cnt, d0 + 1);
        rx_q.delete();

        // Wrap-around stream gated by tx_ready
        tmo = 0;
        for (int i = 0; i < 20; i++) begin
            exp_w[i] = 8'(i * 13 + 5);
            tx_data = exp_w[i];
            tx_valid = 1'b1;
            n = 0;
            while (tx_ready !== 1'b1 && n < 3000) begin
                @(negedge clk);
                n++;
            end
            if (n >= 3000) tmo++;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        check("wrap_ready_timeout", tmo, 0);
        wait_not_busy(20 * 870 + 500, "wrap");
        repeat (2) @(negedge clk);
        check("wrap_rx_cnt", rx_q.size(), 20);
        for (int i = 0; i < 20; i++) begin
            check($sformatf("wrap_rx%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_w[i]});
        end
        check("rx_framing", rx_ferr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87: clock cycles per UART bit period; legal range is 2 or more.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: byte capacity of the transmit buffer; must be a power of two, 2 or more.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk  input  1  system clock; all logic acts on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port tx_data  input  8  byte to enqueue.
REQ-007 SHALL have port tx_valid  input  1  enqueue request for tx_data.
REQ-008 SHALL have port tx_ready  output  1  buffer not full; a write is accepted when tx_valid and tx_ready are both high.
REQ-009 SHALL have port data_out_TX  output  1  serial line, 8N1, idles high; registered output.
REQ-010 SHALL have port tx_busy  output  1  high whenever the FSM is not IDLE.
REQ-011 SHALL have port tx_done  output  1  one-cycle pulse at the end of each stop bit.

Function
REQ-012 SHALL provide a FIFO of FIFO_DEPTH bytes with wrapping read/write pointers and an occupancy counter of width clog2(FIFO_DEPTH+1).
REQ-013 SHALL derive tx_ready combinationally as (count != FIFO_DEPTH).
REQ-014 SHALL silently drop a write attempted while full; FIFO contents and count stay unchanged.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 SHALL, in IDLE with count > 0: pop the head byte into a shift register, enter START, and drive data_out_TX=0 from the same edge.
REQ-017 SHALL, as a result, begin the start bit one cycle after the edge at which a byte is written into an empty, idle block.
REQ-018 SHALL hold every bit for exactly CLKS_PER_BIT cycles, using a bit-period counter that runs 0..CLKS_PER_BIT-1 and wraps to 0.
REQ-019 SHALL, at the end of START, enter DATA and send bit0 first (LSB first).
REQ-020 SHALL send 8 data bits; a 3-bit index advances at each bit-period end; after bit7 the FSM enters STOP with data_out_TX=1.
REQ-021 SHALL, at the end of STOP, pulse tx_done high for exactly 1 cycle.
REQ-022 SHALL, at the STOP-end edge with count > 0, pop the next byte and enter START directly; back-to-back frames have no idle gap.
REQ-023 SHALL, at the STOP-end edge with count = 0, return to IDLE with data_out_TX=1.
REQ-024 SHALL apply a write and a pop on the same edge together: count unchanged, both pointers advance.
REQ-025 SHALL never pop while count = 0, and SHALL never change the byte in flight because of new writes.

Reset
REQ-026 SHALL, while rst=1 at an edge, set: state=IDLE, data_out_TX=1, tx_busy=0, tx_done=0, pointers=0, count=0 (tx_ready=1), bit counter=0, bit index=0.
REQ-027 SHALL, on reset mid-frame, abort the frame: line high on the next edge, no tx_done, buffered bytes discarded.
REQ-028 SHALL give rst priority over a simultaneous tx_valid; the write is dropped.

Verification
REQ-029 SHALL be verified for idle: after reset with no writes for 2000 cycles -> data_out_TX=1, tx_busy=0, tx_done never pulses.
REQ-030 SHALL be verified for a single byte, CLKS_PER_BIT=87: write 8'h4F -> line low 1 cycle after the write; bits 1,1,1,1,0,0,1,0 at 87 cycles each; stop high 87 cycles; tx_done at cycle 870 of the frame; tx_busy then falls.
REQ-031 SHALL be verified for back-to-back: writes 8'h4F, 8'h4B, 8'h0D on consecutive cycles -> 2610 continuous line cycles with no idle gap; 3 tx_done pulses 870 cycles apart; a bench-side receiver decodes "OK\r".
REQ-032 SHALL be verified for full: tx_valid held 10 consecutive cycles from idle with bytes 0x00..0x09 -> tx_ready low after the 9th write; 0x09 dropped; line carries 0x00..0x08 in order.
REQ-033 SHALL be verified for reset mid-frame: rst pulsed during bit3 of 8'hA5, with 3 bytes queued -> line high next cycle; no tx_done; count=0; a following write of 8'h3C transmits correctly.
REQ-034 SHALL be verified for wrap-around: 20 bytes streamed with tx_valid gated by tx_ready -> all 20 received in order; pointers wrap at least twice.
